max7219_serial_rx: RTL and testbench

//   Receive end of the display serial link: accepts din/load/clk as driven by the display output

---
 rtl/max7219_serial_rx.sv | 119 +++++++++++
 tb/tb_max7219_serial_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/max7219_serial_rx.sv
// Receive side of the MAX7219-style display serial link: synchronizes din/load/clk,
// shifts in 16-bit frames and mirrors committed writes into a shadow register file.
module max7219_serial_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_serial_din,
  input  logic        i_serial_load,
  input  logic        i_serial_clk,
  output logic        o_stb,
  output logic [3:0]  o_addr,
  output logic [7:0]  o_data,
  output logic        o_frame_err,
  output logic [63:0] o_digits,
  output logic [7:0]  o_decode_mode,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_shutdown_n,
  output logic        o_test
);

  // Only the address and data fields are ever used, so the shifter keeps just the
  // last 12 bits; the ignored top nibble of a frame simply falls off the end.
  localparam int KEEP_BITS = 12;

  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    return (cnt == 5'd31) ? cnt : cnt + 5'd1;
  endfunction

  logic [SYNC_STAGES-1:0] din_sync, load_sync, sclk_sync;
  logic                   din_p0, load_p0, sclk_p0;
  logic                   load_rise_p0, sclk_rise_p0;
  logic [KEEP_BITS-1:0]   shreg;
  logic [4:0]             bit_cnt;
  logic [3:0]             frm_addr;
  logic [7:0]             frm_data;
  logic [2:0]             digit_sel;
  logic                   frame_ok;

  // Synchronizer chains: bit SYNC_STAGES-1 is the resynchronized level
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      din_sync  <= '0;
      load_sync <= '0;
      sclk_sync <= '0;
    end else begin
      din_sync  <= {din_sync[SYNC_STAGES-2:0],  i_serial_din};
      load_sync <= {load_sync[SYNC_STAGES-2:0], i_serial_load};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_serial_clk};
    end
  end

  // Edge-detect stage: levels and rise pulses registered together so they stay aligned
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      din_p0       <= 1'b0;
      load_p0      <= 1'b0;
      sclk_p0      <= 1'b0;
      load_rise_p0 <= 1'b0;
      sclk_rise_p0 <= 1'b0;
    end else begin
      din_p0       <= din_sync[SYNC_STAGES-1];
      load_p0      <= load_sync[SYNC_STAGES-1];
      sclk_p0      <= sclk_sync[SYNC_STAGES-1];
      load_rise_p0 <= load_sync[SYNC_STAGES-1] & ~load_p0;
      sclk_rise_p0 <= sclk_sync[SYNC_STAGES-1] & ~sclk_p0;
    end
  end

  assign frm_addr  = shreg[11:8];
  assign frm_data  = shreg[7:0];
  assign digit_sel = 3'(frm_addr - 4'd1);
  assign frame_ok  = load_rise_p0 && (bit_cnt == 5'(FRAME_BITS));

  // Shift / commit stage; a load rise outranks a coincident serial-clock rise
  // because load_p0 is already high in that cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      o_stb         <= 1'b0;
      o_frame_err   <= 1'b0;
      o_addr        <= '0;
      o_data        <= '0;
      o_digits      <= '0;
      o_decode_mode <= '0;
      o_intensity   <= '0;
      o_scan_limit  <= '0;
      o_shutdown_n  <= 1'b0;
      o_test        <= 1'b0;
    end else begin
      o_stb       <= frame_ok;
      o_frame_err <= load_rise_p0 && !frame_ok;
      if (load_rise_p0) begin
        bit_cnt <= '0;
      end else if (sclk_rise_p0 && !load_p0) begin
        shreg   <= {shreg[KEEP_BITS-2:0], din_p0};
        bit_cnt <= sat_inc(bit_cnt);
      end
      if (frame_ok) begin
        o_addr <= frm_addr;
        o_data <= frm_data;
        case (frm_addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: o_digits[{digit_sel, 3'b000} +: 8] <= frm_data;
          4'h9:    o_decode_mode <= frm_data;
          4'hA:    o_intensity   <= frm_data[3:0];
          4'hB:    o_scan_limit  <= frm_data[2:0];
          4'hC:    o_shutdown_n  <= frm_data[0];
          4'hF:    o_test        <= frm_data[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_serial_rx.sv
// Randomized bench for max7219_serial_rx: drives the serial link from i_clk-aligned tasks
// and compares every commit against a register-file model of the MAX7219 address map.
module tb_max7219_serial_rx;

  localparam int SYNC_STAGES = 2;
  localparam int PH          = SYNC_STAGES + 2;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_serial_din = 1'b0;
  logic        i_serial_load = 1'b0;
  logic        i_serial_clk = 1'b0;
  logic        o_stb, o_frame_err, o_shutdown_n, o_test;
  logic [3:0]  o_addr, o_intensity;
  logic [7:0]  o_data, o_decode_mode;
  logic [2:0]  o_scan_limit;
  logic [63:0] o_digits;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_dig [8];
  logic [7:0] m_decode, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_scan;
  logic       m_shdn, m_test;

  max7219_serial_rx #(.FRAME_BITS(16), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_serial_din(i_serial_din),
    .i_serial_load(i_serial_load), .i_serial_clk(i_serial_clk),
    .o_stb(o_stb), .o_addr(o_addr), .o_data(o_data), .o_frame_err(o_frame_err),
    .o_digits(o_digits), .o_decode_mode(o_decode_mode), .o_intensity(o_intensity),
    .o_scan_limit(o_scan_limit), .o_shutdown_n(o_shutdown_n), .o_test(o_test)
  );

  always #10 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_dig[k] = 8'h00;
    m_decode = 0; m_int = 0; m_scan = 0; m_shdn = 0; m_test = 0; m_addr = 0; m_data = 0;
  endtask

  // MAX7219 register map applied to a frame that arrived with exactly 16 bits
  task automatic model_write(input logic [15:0] frm);
    logic [3:0] a;
    logic [7:0] d;
    a = frm[11:8];
    d = frm[7:0];
    m_addr = a;
    m_data = d;
    if (a >= 4'h1 && a <= 4'h8) m_dig[a - 4'h1] = d;
    else if (a == 4'h9) m_decode = d;
    else if (a == 4'hA) m_int = d[3:0];
    else if (a == 4'hB) m_scan = d[2:0];
    else if (a == 4'hC) m_shdn = d[0];
    else if (a == 4'hF) m_test = d[0];
  endtask

  task automatic check_regs(input string tag);
    logic [63:0] dig;
    for (int k = 0; k < 8; k++) dig[8*k +: 8] = m_dig[k];
    check({tag, ".digits"},    o_digits, dig);
    check({tag, ".decode"},    64'(o_decode_mode), 64'(m_decode));
    check({tag, ".intensity"}, 64'(o_intensity), 64'(m_int));
    check({tag, ".scan"},      64'(o_scan_limit), 64'(m_scan));
    check({tag, ".shutdown"},  64'(o_shutdown_n), 64'(m_shdn));
    check({tag, ".test"},      64'(o_test), 64'(m_test));
    check({tag, ".addr"},      64'(o_addr), 64'(m_addr));
    check({tag, ".data"},      64'(o_data), 64'(m_data));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_bits(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_serial_din = v[i];
      wait_cyc(PH);
      i_serial_clk = 1'b1;
      wait_cyc(PH);
      i_serial_clk = 1'b0;
    end
    wait_cyc(PH);
  endtask

  // Pulses load (optionally with a coincident serial-clock rise), watches the pulse
  // outputs for a fixed window, then updates the model and checks the register file.
  task automatic commit(input string tag, input int nbits, input logic [15:0] frm, input bit with_sclk);
    int stb_cnt, err_cnt, first;
    stb_cnt = 0; err_cnt = 0; first = 0;
    i_serial_load = 1'b1;
    if (with_sclk) begin
      i_serial_clk = 1'b1;
      i_serial_din = 1'b1;
    end
    for (int c = 1; c <= 16; c++) begin
      @(posedge i_clk);
      #1;
      if (o_stb) stb_cnt++;
      if (o_frame_err) err_cnt++;
      if ((o_stb || o_frame_err) && first == 0) first = c;
      if (c == PH + 1) begin
        @(negedge i_clk);
        i_serial_load = 1'b0;
        i_serial_clk  = 1'b0;
        i_serial_din  = 1'b0;
      end
    end
    if (nbits == 16) begin
      check({tag, ".stb_cnt"}, 64'(stb_cnt), 64'd1);
      check({tag, ".err_cnt"}, 64'(err_cnt), 64'd0);
      model_write(frm);
    end else begin
      check({tag, ".stb_cnt"}, 64'(stb_cnt), 64'd0);
      check({tag, ".err_cnt"}, 64'(err_cnt), 64'd1);
    end
    check({tag, ".latency"}, 64'(first - 1), 64'(SYNC_STAGES + 1));
    check_regs(tag);
    wait_cyc(2);
  endtask

  task automatic frame(input string tag, input logic [15:0] frm);
    send_bits(40'(frm), 16);
    commit(tag, 16, frm, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pulses"}, {62'd0, o_stb, o_frame_err}, 64'd0);
    check({tag, ".digits"}, o_digits, 64'd0);
    check({tag, ".cfg"}, {36'd0, o_addr, o_data, o_decode_mode, o_intensity, o_scan_limit,
                          o_shutdown_n, o_test}, 64'd0);
  endtask

  initial begin
    logic [39:0] v;
    int len;
    model_reset();
    wait_cyc(3);
    check_all_zero("reset");
    i_reset_n = 1'b1;
    wait_cyc(3);
    check_all_zero("idle");

    frame("t1", 16'h0C01);
    frame("t2a", 16'h0312);
    frame("t2b", 16'h0A07);

    send_bits(40'h7FFF, 15);
    commit("t3err", 15, 16'h0, 1'b0);
    frame("t3", 16'h0105);

    send_bits(40'h1FFFF, 17);
    commit("t4err", 17, 16'h0, 1'b0);
    frame("t4", 16'h0000);
    frame("t4nop", 16'hFD55);

    send_bits(40'h0A05, 16);
    commit("coinc", 16, 16'h0A05, 1'b1);

    // Asynchronous reset in the middle of a frame
    send_bits(40'h0B, 8);
    #3 i_reset_n = 1'b0;
    #1 check_all_zero("t5rst");
    wait_cyc(2);
    check_all_zero("t5hold");
    model_reset();
    i_reset_n = 1'b1;
    wait_cyc(3);
    frame("t5", 16'h0B03);

    // Display-wrapper style traffic: configuration then three time snapshots
    frame("cfg.test", 16'h0F00);
    frame("cfg.scan", 16'h0B05);
    frame("cfg.dec", 16'h09FF);
    frame("cfg.int", 16'h0A08);
    frame("cfg.shdn", 16'h0C01);
    check("cfg.shutdown_n", 64'(o_shutdown_n), 64'd1);
    begin
      logic [7:0] t [3][6] = '{'{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                               '{8'h1, 8'h2, 8'h3, 8'h0, 8'h5, 8'h9},
                               '{8'h2, 8'h3, 8'h1, 8'h5, 8'h3, 8'h0}};
      for (int s = 0; s < 3; s++)
        for (int k = 0; k < 6; k++)
          frame($sformatf("time%0d.d%0d", s, k), {4'h0, 4'(k + 1), t[s][k]});
    end

    for (int r = 0; r < 50; r++) begin
      v = {$urandom, $urandom};
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : 16;
      send_bits(v, len);
      commit($sformatf("rnd%0d", r), len, v[15:0], 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
